// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM duty path: ramp FSM states and the default
// PWM period, which the PWM generator must also use so both counters line up.
package pwm_pkg;

  typedef enum logic [0:0] {
    StIdle,
    StRamp
  } state_e;

  localparam int unsigned DefaultPeriod = 15;

endpackage

// File: rtl/pwm_period_timer.sv
// Free-running PWM period counter with period tick, plus a divider that
// turns every STEP_DIV-th period tick into a ramp step event.
module pwm_period_timer #(
  parameter int unsigned PERIOD   = 15,
  parameter int unsigned STEP_DIV = 1
) (
  input  logic clk,
  input  logic rst_n,
  output logic period_tick,
  output logic step_evt
);

  localparam int unsigned PcntW = (PERIOD > 0) ? $clog2(PERIOD + 1) : 1;
  localparam int unsigned DcntW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [PcntW-1:0] PcntLast = PcntW'(PERIOD);
  localparam logic [DcntW-1:0] DcntLast = DcntW'(STEP_DIV - 1);

  logic [PcntW-1:0] pcnt_q, pcnt_d;
  logic [DcntW-1:0] dcnt_q, dcnt_d;

  always_comb begin
    period_tick = (pcnt_q == PcntLast);
    step_evt    = period_tick && (dcnt_q == DcntLast);
  end

  always_comb begin
    pcnt_d = period_tick ? '0 : pcnt_q + PcntW'(1);
    dcnt_d = dcnt_q;
    if (period_tick) begin
      dcnt_d = (dcnt_q == DcntLast) ? '0 : dcnt_q + DcntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pcnt_q <= '0;
      dcnt_q <= '0;
    end else begin
      pcnt_q <= pcnt_d;
      dcnt_q <= dcnt_d;
    end
  end

endmodule

// File: rtl/pwm_duty_ramp.sv
// Slew-limited duty source feeding the PWM generator. Define PWM_RAMP_CLAMP_EN
// to clamp accepted targets to DUTY_MAX; otherwise targets are taken as given.
module pwm_duty_ramp
  import pwm_pkg::*;
#(
  parameter int unsigned N        = 3,
  parameter int unsigned PERIOD   = DefaultPeriod,
  parameter int unsigned STEP     = 1,
  parameter int unsigned STEP_DIV = 1,
  parameter int unsigned DUTY_MAX = (1 << (N + 1)) - 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [N:0] tgt_duty,
  input  logic       tgt_valid,
  output logic       tgt_ready,
  output logic [N:0] pwm_duty,
  output logic       period_tick,
  output logic       busy
);

  localparam logic [N+1:0] StepW = (N + 2)'(STEP);

  state_e       state_q, state_d;
  logic [N:0]   target_q, target_d;
  logic [N:0]   duty_q, duty_d;
  logic [N:0]   accepted;
  logic [N:0]   stepped;
  logic [N+1:0] duty_x, target_x, up_sum, dn_lim;
  logic         rdy_en_q;
  logic         step_evt;

  pwm_period_timer #(
    .PERIOD  (PERIOD),
    .STEP_DIV(STEP_DIV)
  ) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .period_tick(period_tick),
    .step_evt   (step_evt)
  );

`ifdef PWM_RAMP_CLAMP_EN
  localparam logic [N:0] DutyMaxW = (N + 1)'(DUTY_MAX);

  always_comb begin
    accepted = (tgt_duty > DutyMaxW) ? DutyMaxW : tgt_duty;
  end
`else
  always_comb begin
    accepted = tgt_duty;
  end
`endif

  // One step toward the target in N+2 bits, saturating at the target itself.
  always_comb begin
    duty_x   = {1'b0, duty_q};
    target_x = {1'b0, target_q};
    up_sum   = duty_x + StepW;
    dn_lim   = target_x + StepW;
    if (target_x > duty_x) begin
      stepped = (up_sum > target_x) ? target_q : up_sum[N:0];
    end else if (duty_x > dn_lim) begin
      stepped = duty_q - StepW[N:0];
    end else begin
      stepped = target_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    duty_d   = duty_q;
    unique case (state_q)
      StIdle: begin
        if (tgt_valid && tgt_ready) begin
          target_d = accepted;
          if (accepted != duty_q) begin
            state_d = StRamp;
          end
        end
      end
      StRamp: begin
        if (step_evt) begin
          duty_d = stepped;
          if (stepped == target_q) begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // rdy_en_q holds tgt_ready low for the first cycle after reset is sampled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      target_q <= '0;
      duty_q   <= '0;
      rdy_en_q <= 1'b0;
    end else begin
      target_q <= target_d;
      duty_q   <= duty_d;
      rdy_en_q <= 1'b1;
    end
  end

  always_comb begin
    busy      = (state_q == StRamp);
    tgt_ready = (state_q == StIdle) && rdy_en_q;
    pwm_duty  = duty_q;
  end

endmodule

// File: tb/tb_pwm_duty_ramp.sv
// Directed bench for pwm_duty_ramp: three instances cover STEP=1, STEP=4 and
// STEP_DIV=3; checks are immediate assertions sampled on the falling edge.
module tb_pwm_duty_ramp;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] tgt_a, tgt_b, tgt_c;
  logic       vld_a, vld_b, vld_c;
  logic       rdy_a, rdy_b, rdy_c;
  logic [3:0] duty_a, duty_b, duty_c;
  logic       tick_a, tick_b, tick_c;
  logic       busy_a, busy_b, busy_c;

  int checks = 0;
  int fails  = 0;
  int dt;
  int ticks;

  always #5 clk = ~clk;

  pwm_duty_ramp #(.N(3), .PERIOD(15), .STEP(1), .STEP_DIV(1), .DUTY_MAX(12)) u_a (
    .clk(clk), .rst_n(rst_n), .tgt_duty(tgt_a), .tgt_valid(vld_a), .tgt_ready(rdy_a),
    .pwm_duty(duty_a), .period_tick(tick_a), .busy(busy_a)
  );

  pwm_duty_ramp #(.N(3), .PERIOD(15), .STEP(4), .STEP_DIV(1), .DUTY_MAX(15)) u_b (
    .clk(clk), .rst_n(rst_n), .tgt_duty(tgt_b), .tgt_valid(vld_b), .tgt_ready(rdy_b),
    .pwm_duty(duty_b), .period_tick(tick_b), .busy(busy_b)
  );

  pwm_duty_ramp #(.N(3), .PERIOD(15), .STEP(1), .STEP_DIV(3), .DUTY_MAX(15)) u_c (
    .clk(clk), .rst_n(rst_n), .tgt_duty(tgt_c), .tgt_valid(vld_c), .tgt_ready(rdy_c),
    .pwm_duty(duty_c), .period_tick(tick_c), .busy(busy_c)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] get_duty(input int which);
    case (which)
      0:       return duty_a;
      1:       return duty_b;
      default: return duty_c;
    endcase
  endfunction

  // Wait (bounded) for the selected duty to change, then check its new value.
  task automatic wait_step(input int which, input logic [3:0] exp, input string tag,
                           output int cycles);
    logic [3:0] prev;
    logic [3:0] cur;
    prev   = get_duty(which);
    cur    = prev;
    cycles = 0;
    while (cur == prev && cycles < 200) begin
      @(negedge clk);
      cycles++;
      cur = get_duty(which);
    end
    if (cur == prev) check({tag, "_timeout"}, 32'(cycles), 32'(0));
    check(tag, 32'(cur), 32'(exp));
  endtask

  initial begin
    rst_n = 1'b0;
    tgt_a = '0; tgt_b = '0; tgt_c = '0;
    vld_a = 1'b0; vld_b = 1'b0; vld_c = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_duty_a", 32'(duty_a), 32'(0));
    check("rst_busy_a", 32'(busy_a), 32'(0));
    check("rst_ready_a", 32'(rdy_a), 32'(0));
    check("rst_ready_b", 32'(rdy_b), 32'(0));

    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_rst", 32'(rdy_a), 32'(1));

    ticks = 0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      if (tick_a) ticks++;
    end
    check("ticks_per_32", 32'(ticks), 32'(2));

    // STEP=1: 0 -> 5, one change per 16 cycles.
    tgt_a = 4'd5; vld_a = 1'b1;
    @(negedge clk);
    vld_a = 1'b0;
    check("busy_on_accept", 32'(busy_a), 32'(1));
    check("ready_on_accept", 32'(rdy_a), 32'(0));
    for (int k = 1; k <= 5; k++) begin
      wait_step(0, 4'(k), "a_up_step", dt);
      if (k >= 2) check("a_up_interval", 32'(dt), 32'(16));
      if (k < 5) check("a_busy_mid", 32'(busy_a), 32'(1));
    end
    check("a_busy_done", 32'(busy_a), 32'(0));
    check("a_ready_done", 32'(rdy_a), 32'(1));

    // Target equal to current duty: no ramp.
    tgt_a = 4'd5; vld_a = 1'b1;
    @(negedge clk);
    vld_a = 1'b0;
    check("same_busy", 32'(busy_a), 32'(0));
    check("same_ready", 32'(rdy_a), 32'(1));
    repeat (40) @(negedge clk);
    check("same_duty_hold", 32'(duty_a), 32'(5));
    check("same_busy_hold", 32'(busy_a), 32'(0));

    // Target 8; tgt_valid with 0 during the ramp must be ignored.
    tgt_a = 4'd8; vld_a = 1'b1;
    @(negedge clk);
    tgt_a = 4'd0;
    check("retgt_busy", 32'(busy_a), 32'(1));
    wait_step(0, 4'd6, "retgt_s6", dt);
    wait_step(0, 4'd7, "retgt_s7", dt);
    vld_a = 1'b0;
    wait_step(0, 4'd8, "retgt_s8", dt);
    repeat (40) @(negedge clk);
    check("retgt_final", 32'(duty_a), 32'(8));
    check("retgt_idle", 32'(busy_a), 32'(0));

    // Ramp down from 8 and reset when duty reaches 3.
    tgt_a = 4'd0; vld_a = 1'b1;
    @(negedge clk);
    vld_a = 1'b0;
    for (int k = 7; k >= 3; k--) wait_step(0, 4'(k), "a_dn_step", dt);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_duty", 32'(duty_a), 32'(0));
    check("midrst_busy", 32'(busy_a), 32'(0));
    check("midrst_ready", 32'(rdy_a), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Target 15: clamped to DUTY_MAX=12 only when the clamp is built in.
    tgt_a = 4'd15; vld_a = 1'b1;
    @(negedge clk);
    vld_a = 1'b0;
    dt = 0;
    while (busy_a && dt < 400) begin
      @(negedge clk);
      dt++;
    end
    check("clamp_done_in_time", 32'(busy_a), 32'(0));
`ifdef PWM_RAMP_CLAMP_EN
    check("clamp_final", 32'(duty_a), 32'(12));
`else
    check("clamp_final", 32'(duty_a), 32'(15));
`endif

    // STEP=4: 0 -> 6 without overshoot, then up to 15, then down to 2.
    tgt_b = 4'd6; vld_b = 1'b1;
    @(negedge clk);
    vld_b = 1'b0;
    wait_step(1, 4'd4, "b_up4", dt);
    wait_step(1, 4'd6, "b_up6", dt);
    check("b_idle_at6", 32'(busy_b), 32'(0));
    tgt_b = 4'd15; vld_b = 1'b1;
    @(negedge clk);
    vld_b = 1'b0;
    wait_step(1, 4'd10, "b_up10", dt);
    wait_step(1, 4'd14, "b_up14", dt);
    wait_step(1, 4'd15, "b_up15", dt);
    tgt_b = 4'd2; vld_b = 1'b1;
    @(negedge clk);
    vld_b = 1'b0;
    wait_step(1, 4'd11, "b_dn11", dt);
    wait_step(1, 4'd7, "b_dn7", dt);
    wait_step(1, 4'd3, "b_dn3", dt);
    wait_step(1, 4'd2, "b_dn2", dt);
    check("b_idle_at2", 32'(busy_b), 32'(0));
    repeat (20) @(negedge clk);
    check("b_hold2", 32'(duty_b), 32'(2));

    // STEP_DIV=3: steps 48 cycles apart.
    tgt_c = 4'd2; vld_c = 1'b1;
    @(negedge clk);
    vld_c = 1'b0;
    wait_step(2, 4'd1, "c_s1", dt);
    wait_step(2, 4'd2, "c_s2", dt);
    check("c_interval", 32'(dt), 32'(48));
    check("c_idle", 32'(busy_c), 32'(0));

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

// File: doc/pwm_duty_ramp.md
# pwm_duty_ramp

Soft-start / slew-limited duty source placed directly upstream of the PWM generator; drives its `pwm_duty` input. Accepts a target duty over a valid/ready handshake and walks the output duty toward it by a fixed step at PWM period boundaries, so the load never sees a duty jump. It keeps a free-running period counter matched to the generator's period and exports a period tick.

## Interface
- `N`, 3: duty MSB index; duty width is N+1 bits.
- `PERIOD`, 15: PWM period length minus one, in clk cycles; the period is PERIOD+1 cycles.
- `STEP`, 1: duty increment per step; must satisfy 1 ≤ STEP ≤ 2^(N+1)−1.
- `STEP_DIV`, 1: number of period ticks per step; must be ≥ 1.
- `DUTY_MAX`, 2^(N+1)−1: clamp ceiling, used only with PWM_RAMP_CLAMP_EN.
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `tgt_duty`  in  N+1  requested target duty.
- `tgt_valid`  in  1  tgt_duty is valid.
- `tgt_ready`  out  1  block can accept a new target.
- `pwm_duty`  out  N+1  current duty, registered; feeds the PWM generator.
- `period_tick`  out  1  one-cycle pulse on the last cycle of each period.
- `busy`  out  1  high while in RAMP.

## Operation
- Period counter `pcnt`, 0..PERIOD, wraps to 0. `period_tick` = (pcnt==PERIOD).
- Step divider `dcnt`, 0..STEP_DIV−1, advances on each period_tick. A step event is period_tick && dcnt==STEP_DIV−1.
- States:
  - IDLE: tgt_ready=1, busy=0.
  - RAMP: tgt_ready=0, busy=1.
- IDLE, on tgt_valid && tgt_ready: latch the target (clamped, if the macro is defined).
  - If the latched target ≠ pwm_duty, go to RAMP.
  - Otherwise stay in IDLE; pwm_duty is unchanged.
- RAMP, on a step event:
  - If target > duty: duty ← min(duty+STEP, target).
  - If target < duty: duty ← max(duty−STEP, target).
  - If the new duty equals the target, go to IDLE in the same update.
- Arithmetic is done in N+2 bits. There is no overshoot and no wrap-around past 0 or 2^(N+1)−1.
- A target is never retargeted mid-ramp; tgt_valid is ignored while tgt_ready=0.
- dcnt is not reset on target acceptance. The first step of a ramp occurs at the next step event.
- Simultaneous acceptance and step event in IDLE: acceptance only. Stepping starts at the following step event.

## Timing
- Reset (rst_n low at a rising edge):
  - Registered outputs next cycle: pwm_duty=0, busy=0, tgt_ready=0.
  - Internal state: pcnt=0, dcnt=0, target=0, state=IDLE.
  - tgt_ready is forced to 0 while rst_n is low and goes to 1 in the first cycle after rst_n is sampled high.
- Reset mid-ramp aborts the ramp immediately; pwm_duty returns to 0 with no ramp down.
- Acceptance at edge t: target register and state are valid after edge t. busy is high from cycle t+1 when the target differs.
- pwm_duty changes only on the edge that ends a step-event cycle. It is therefore stable for whole periods and aligned to the generator's reload point.
- After the final step: busy falls and tgt_ready rises in the same cycle pwm_duty reaches the target.
- Ramp duration: ceil(|target−duty|/STEP) × STEP_DIV periods, plus up to one partial period.

## Configuration
- PWM_RAMP_CLAMP_EN defined: the accepted target is min(tgt_duty, DUTY_MAX).
- PWM_RAMP_CLAMP_EN undefined: tgt_duty is latched unmodified and DUTY_MAX is unused.
- No other behaviour differs between the two builds.

## Structure
- Shared package `pwm_pkg`:
  - State enum (IDLE, RAMP).
  - Default-period constant, shared with the PWM generator so that PERIOD matches.
- One sub-module, `pwm_period_timer`: pcnt, period_tick and the STEP_DIV divider, emitting step_evt. The top holds the FSM, target register and step arithmetic.

## Test plan
- N=3, PERIOD=15, STEP=1, STEP_DIV=1; target 5 from reset -> pwm_duty steps 1,2,3,4,5, one change per 16 cycles; busy low and tgt_ready high the cycle duty reaches 5.
- STEP=4; target 6 from duty 0 -> 4 then 6; no overshoot to 8.
- Duty 15, target 2, STEP=4 -> 11,7,3,2; no underflow.
- STEP_DIV=3; target 2 from 0 -> steps 48 cycles apart.
- Target equal to current duty -> no transition to RAMP; busy stays 0; tgt_ready stays 1. tgt_valid during RAMP -> ignored, final duty is the original target.
- rst_n low mid-ramp at duty 3 -> next cycle pwm_duty=0, busy=0. With PWM_RAMP_CLAMP_EN and DUTY_MAX=12, target 15 -> ramp ends at 12; without the macro it ends at 15.
